// File: rtl/spectrum_frame_writer.sv
// Spectrum display RAM writer: per-bin approximate magnitude of streaming FFT output,
// ping-pong bank selection swapped on vsync, and per-frame peak bin reporting.
module spectrum_frame_writer #(
   parameter int FFT_LEN = 2048,
   parameter int BINS    = 1024,
   parameter int AW      = 10,
   parameter int MAG_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   input  logic             s_last,
   input  logic [63:0]      s_data,
   input  logic             vsync_pulse,
   output logic             ram_wr_en,
   output logic [AW:0]      ram_wr_addr,
   output logic [MAG_W-1:0] ram_wr_data,
   output logic             rd_bank,
   output logic             frame_done,
   output logic             frame_err,
   output logic             frame_drop,
   output logic [AW-1:0]    peak_bin,
   output logic [MAG_W-1:0] peak_mag
);

   localparam int CW = $clog2(FFT_LEN);
   localparam logic [CW-1:0] LAST_IDX = CW'(FFT_LEN - 1);
   localparam logic [CW:0]   BINS_C   = (CW + 1)'(BINS);
   localparam logic [34:0]   MAG_MAX  = {{(35 - MAG_W){1'b0}}, {MAG_W{1'b1}}};

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DROP} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic [1:0]       drain_cnt_q, drain_cnt_d;
   logic             wr_bank_q, wr_bank_d;
   logic             pending_q, pending_d;
   logic             rd_bank_q, rd_bank_d;
   logic             frame_done_q, frame_done_d;
   logic             frame_err_q, frame_err_d;
   logic             frame_drop_q, frame_drop_d;
   logic [AW-1:0]    peak_bin_q, peak_bin_d;
   logic [MAG_W-1:0] peak_mag_q, peak_mag_d;
   logic [AW-1:0]    run_bin_q, run_bin_d;
   logic [MAG_W-1:0] run_max_q, run_max_d;

   logic             s1_v_q, s1_v_d;
   logic [AW:0]      s1_addr_q, s1_addr_d;
   logic [33:0]      s1_re_q, s1_re_d, s1_im_q, s1_im_d;
   logic             s2_v_q, s2_v_d;
   logic [AW:0]      s2_addr_q, s2_addr_d;
   logic [33:0]      s2_max_q, s2_max_d, s2_min_q, s2_min_d;
   logic             ram_wr_en_q, ram_wr_en_d;
   logic [AW:0]      ram_wr_addr_q, ram_wr_addr_d;
   logic [MAG_W-1:0] ram_wr_data_q, ram_wr_data_d;

   logic             wr_fire;
   logic [CW-1:0]    wr_idx;
   logic             bank_sel;
   logic             last_pos;
   logic             in_bins;
   logic [33:0]      re_ext, im_ext;
   logic [34:0]      sum_w;

   // NOTE: every signal gets a default at the top so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      drain_cnt_d   = drain_cnt_q;
      wr_bank_d     = wr_bank_q;
      pending_d     = pending_q;
      rd_bank_d     = rd_bank_q;
      frame_done_d  = 1'b0;
      frame_err_d   = 1'b0;
      frame_drop_d  = 1'b0;
      peak_bin_d    = peak_bin_q;
      peak_mag_d    = peak_mag_q;
      run_bin_d     = run_bin_q;
      run_max_d     = run_max_q;
      wr_fire       = 1'b0;
      wr_idx        = idx_q;
      bank_sel      = wr_bank_q;
      last_pos      = (idx_q == LAST_IDX);
      in_bins       = ({1'b0, idx_q} < BINS_C);

      if (vsync_pulse && pending_q) begin
         rd_bank_d = ~rd_bank_q;
         pending_d = 1'b0;
      end

      // Running peak follows the written magnitudes as they leave the pipeline.
      if (ram_wr_en_q) begin
         if (ram_wr_addr_q[AW-1:0] == '0 || ram_wr_data_q > run_max_q) begin
            run_max_d = ram_wr_data_q;
            run_bin_d = ram_wr_addr_q[AW-1:0];
         end
      end

      case (state_q)
         IDLE: begin
            if (s_valid) begin
               if (!pending_q || vsync_pulse) begin
                  bank_sel  = ~rd_bank_d;
                  wr_bank_d = bank_sel;
                  wr_idx    = '0;
                  if (s_last) begin
                     frame_err_d = 1'b1;
                  end else begin
                     wr_fire = 1'b1;
                     idx_d   = CW'(1);
                     state_d = CAPTURE;
                  end
               end else begin
                  frame_drop_d = 1'b1;
                  state_d      = s_last ? IDLE : DROP;
               end
            end
         end
         CAPTURE: begin
            if (s_valid) begin
               idx_d = idx_q + 1'b1;
               if (s_last && last_pos) begin
                  wr_fire     = in_bins;
                  idx_d       = '0;
                  drain_cnt_d = '0;
                  state_d     = DRAIN;
               end else if (s_last) begin
                  frame_err_d = 1'b1;
                  idx_d       = '0;
                  state_d     = IDLE;
               end else if (last_pos) begin
                  wr_fire     = in_bins;
                  frame_err_d = 1'b1;
                  idx_d       = '0;
                  state_d     = DROP;
               end else begin
                  wr_fire = in_bins;
               end
            end
         end
         DRAIN: begin
            drain_cnt_d = drain_cnt_q + 2'd1;
            if (drain_cnt_q == 2'd2) begin
               frame_done_d = 1'b1;
               pending_d    = 1'b1;
               peak_bin_d   = run_bin_d;
               peak_mag_d   = run_max_d;
               state_d      = IDLE;
            end
         end
         DROP: begin
            if (s_valid && s_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      re_ext    = {{2{s_data[31]}}, s_data[31:0]};
      im_ext    = {{2{s_data[63]}}, s_data[63:32]};
      s1_v_d    = wr_fire;
      s1_addr_d = {bank_sel, wr_idx[AW-1:0]};
      s1_re_d   = re_ext[33] ? (~re_ext + 34'd1) : re_ext;
      s1_im_d   = im_ext[33] ? (~im_ext + 34'd1) : im_ext;

      s2_v_d    = s1_v_q;
      s2_addr_d = s1_addr_q;
      s2_max_d  = (s1_re_q > s1_im_q) ? s1_re_q : s1_im_q;
      s2_min_d  = (s1_re_q > s1_im_q) ? s1_im_q : s1_re_q;

      sum_w         = {1'b0, s2_max_q} + {3'b0, s2_min_q[33:2]} + {4'b0, s2_min_q[33:3]};
      ram_wr_en_d   = s2_v_q;
      ram_wr_addr_d = s2_addr_q;
      ram_wr_data_d = (sum_w > MAG_MAX) ? {MAG_W{1'b1}} : sum_w[MAG_W-1:0];
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         drain_cnt_q   <= '0;
         wr_bank_q     <= 1'b1;
         pending_q     <= 1'b0;
         rd_bank_q     <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         frame_drop_q  <= 1'b0;
         peak_bin_q    <= '0;
         peak_mag_q    <= '0;
         run_bin_q     <= '0;
         run_max_q     <= '0;
         s1_v_q        <= 1'b0;
         s1_addr_q     <= '0;
         s1_re_q       <= '0;
         s1_im_q       <= '0;
         s2_v_q        <= 1'b0;
         s2_addr_q     <= '0;
         s2_max_q      <= '0;
         s2_min_q      <= '0;
         ram_wr_en_q   <= 1'b0;
         ram_wr_addr_q <= '0;
         ram_wr_data_q <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         drain_cnt_q   <= drain_cnt_d;
         wr_bank_q     <= wr_bank_d;
         pending_q     <= pending_d;
         rd_bank_q     <= rd_bank_d;
         frame_done_q  <= frame_done_d;
         frame_err_q   <= frame_err_d;
         frame_drop_q  <= frame_drop_d;
         peak_bin_q    <= peak_bin_d;
         peak_mag_q    <= peak_mag_d;
         run_bin_q     <= run_bin_d;
         run_max_q     <= run_max_d;
         s1_v_q        <= s1_v_d;
         s1_addr_q     <= s1_addr_d;
         s1_re_q       <= s1_re_d;
         s1_im_q       <= s1_im_d;
         s2_v_q        <= s2_v_d;
         s2_addr_q     <= s2_addr_d;
         s2_max_q      <= s2_max_d;
         s2_min_q      <= s2_min_d;
         ram_wr_en_q   <= ram_wr_en_d;
         ram_wr_addr_q <= ram_wr_addr_d;
         ram_wr_data_q <= ram_wr_data_d;
      end
   end

   assign ram_wr_en   = ram_wr_en_q;
   assign ram_wr_addr = ram_wr_addr_q;
   assign ram_wr_data = ram_wr_data_q;
   assign rd_bank     = rd_bank_q;
   assign frame_done  = frame_done_q;
   assign frame_err   = frame_err_q;
   assign frame_drop  = frame_drop_q;
   assign peak_bin    = peak_bin_q;
   assign peak_mag    = peak_mag_q;

endmodule

// File: doc/spectrum_frame_writer.md
Name: spectrum_frame_writer

Overview:
Writer side of the spectrum display RAM. Takes the streaming complex FFT output (valid/last), computes an approximate magnitude per bin, and writes the first BINS bins of each frame into one half of a ping-pong display RAM. Bank swaps happen only on a display vsync pulse after a complete frame, so the pixel-clock reader never shows a half-written spectrum. Also reports the per-frame peak bin and its magnitude.

Parameters:
FFT_LEN, 2048, samples per FFT frame (s_last expected on sample FFT_LEN-1)
BINS, 1024, bins written per frame (0..BINS-1); remaining samples discarded
AW, 10, log2(BINS)
MAG_W, 32, stored magnitude width, unsigned

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous reset, active-high
s_valid  in  1  FFT output sample valid; no backpressure
s_last  in  1  last sample of FFT frame, qualified by s_valid
s_data  in  64  [63:32] imag, [31:0] real, both signed two's complement
vsync_pulse  in  1  one-cycle display frame-boundary pulse, already in clk domain
ram_wr_en  out  1  RAM write strobe
ram_wr_addr  out  AW+1  {write bank, bin index}
ram_wr_data  out  MAG_W  magnitude
rd_bank  out  1  bank the display reader uses
frame_done  out  1  one-cycle pulse, complete frame written
frame_err  out  1  one-cycle pulse, length error (early or missing s_last)
frame_drop  out  1  one-cycle pulse, frame discarded because a swap is still pending
peak_bin  out  AW  bin index of the largest magnitude in the last completed frame
peak_mag  out  MAG_W  magnitude at peak_bin

Behaviour:
- Reset: all outputs 0; FSM in IDLE; pending=0; sample counter 0; write bank = ~rd_bank = 1.
- Magnitude, 3-stage pipeline: S1 takes abs of re/im (34-bit, so -2^31 is exact); S2 computes max, min; S3 computes max + (min>>2) + (min>>3), saturated to 2^MAG_W-1.
- Latency: sample accepted in cycle t -> ram_wr_en in cycle t+3.
- ram_wr_en asserts only for samples with index < BINS in an accepted frame. Address = {~rd_bank captured at frame start, index[AW-1:0]}.
- FSM IDLE:
  - s_valid && !pending -> CAPTURE; this sample is index 0.
  - s_valid && pending -> DROP with a frame_drop pulse. Exception: if vsync_pulse arrives in the same cycle, the swap happens first and the frame is accepted.
- FSM CAPTURE:
  - Counts each s_valid.
  - s_last at index FFT_LEN-1 -> DRAIN.
  - s_last at index < FFT_LEN-1 -> frame_err, then IDLE; pending is not set and the partial data is discarded.
  - Index FFT_LEN-1 without s_last -> frame_err, then DROP.
- FSM DRAIN: waits 3 cycles for the pipeline to empty. Then pulses frame_done, sets pending, loads peak_bin/peak_mag, and returns to IDLE.
- FSM DROP: ignores data; returns to IDLE on s_valid && s_last. Makes no RAM writes.
- Peak tracking: a running max over written bins only; a strict greater-than update keeps the lowest index on ties; reset at index 0. Outputs update only at frame_done.
- Swap: vsync_pulse && pending -> rd_bank toggles, pending cleared, same cycle. vsync with pending=0 does nothing.
- A frame accepted after a swap writes the new ~rd_bank. Writes never target the current rd_bank.
- Reset mid-frame: no further writes; rd_bank returns to 0; the partial frame is never displayed.
- Counter widths: index counter wide enough for FFT_LEN-1, with no wrap inside a frame.

Test Plan:
- Clean frame: 2048 valid samples, sample k = (re=k, im=0), s_last on #2047 -> 1024 writes, addr {1,k}, data k at k+3 cycles; frame_done once; peak_bin=1023, peak_mag=1023; rd_bank stays 0 until vsync_pulse, then 1.
- Magnitude: re=3000, im=-4000 -> 5125. re=-2^31, im=0 -> 2147483648. re=im=-2^31 -> 2952790016, no saturation at MAG_W=32.
- Short frame: s_last at index 500 -> frame_err, 500 writes observed, no frame_done, pending stays 0, next vsync gives no swap.
- Two frames, no vsync between -> second frame gives frame_drop and no writes. A third frame starting in the same cycle as vsync_pulse is accepted and writes to bank 0.
- Long frame: 2100 samples, no s_last until #2099 -> frame_err at index 2047, DROP until s_last, back to IDLE, next clean frame accepted.
- Assert rst at index 700 of a frame -> outputs 0 immediately, no later writes; the next frame writes bank 1.
